// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   scan_state_t  : scanner FSM states
//   COL0..COL3    : one-hot column drive patterns for col_idx 0..3
//   ROW_W/COL_W   : widths of the key_code fields {row_idx, col_idx}
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD,
        RELEASE
    } scan_state_t;

    localparam int ROW_W      = 2;
    localparam int COL_W      = 2;
    localparam int KEY_CODE_W = ROW_W + COL_W;

    localparam logic [3:0] COL0      = 4'b1000;
    localparam logic [3:0] COL1      = 4'b0100;
    localparam logic [3:0] COL2      = 4'b0010;
    localparam logic [3:0] COL3      = 4'b0001;
    localparam logic [3:0] COL_RESET = COL0;

    function automatic logic [3:0] col_drive(input logic [COL_W-1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = COL0;
            2'd1:    drv = COL1;
            2'd2:    drv = COL2;
            default: drv = COL3;
        endcase
        return drv;
    endfunction

    // Lowest conducting row wins when several rows are active.
    function automatic logic [ROW_W-1:0] lowest_row(input logic [3:0] rows);
        logic [ROW_W-1:0] idx;
        if (rows[0])      idx = 2'd0;
        else if (rows[1]) idx = 2'd1;
        else if (rows[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input
//   q     : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner and debounced key-event generator for a 4x4 matrix keypad.
//   clk        : system clock
//   n_reset    : asynchronous active-low reset
//   filas_raw  : raw row lines (bit r = row r conducting to active column)
//   columnas   : one-hot active-high column drive (1000 = col_idx 0)
//   key_code   : {row_idx, col_idx} of the last accepted key
//   key_valid  : one-cycle pulse when a key is accepted
//   key_held   : high while the accepted key is down or releasing
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 27_000,
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [3:0]            filas_raw,
    output logic [3:0]            columnas,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] filas_s;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst_n (n_reset),
        .d     (filas_raw),
        .q     (filas_s)
    );

    scan_state_t             state_d, state_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic [COL_W-1:0]        col_idx_d, col_idx_q;
    logic [ROW_W-1:0]        row_idx_d, row_idx_q;
    logic [KEY_CODE_W-1:0]   key_code_d, key_code_q;
    logic                    key_valid_d, key_valid_q;
    logic                    key_held_d, key_held_q;
    logic                    row_bit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        row_bit     = filas_s[row_idx_q];

        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (|filas_s) begin
                        row_idx_d = lowest_row(filas_s);
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!row_bit) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    key_code_d  = {row_idx_q, col_idx_q};
                    key_valid_d = 1'b1;
                    state_d     = HOLD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!row_bit) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (row_bit) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = SCAN;
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase

        // Registered one cycle after entering HOLD so it trails key_valid,
        // but drops on the same edge the scanner returns to SCAN.
        key_held_d = ((state_q == HOLD) || (state_q == RELEASE)) &&
                     ((state_d == HOLD) || (state_d == RELEASE));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign columnas  = col_drive(col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan sequencer and key-event generator for the 4x4 matrix keypad. It drives the one-hot column lines and samples the raw row lines. It debounces press and release, and emits exactly one `key_valid` pulse with an encoded `key_code` per physical key press. It sits between the keypad pins and the downstream entry/display logic, and replaces free-running column cycling with a scanner that freezes on a pressed key.

## Interface
- `SCAN_CYCLES`, 27_000: clock cycles each column stays active (1 ms at 27 MHz).
- `DEBOUNCE_CYCLES`, 270_000: cycles a press or release must be stable (10 ms at 27 MHz).
- `clk`  in  1  system clock.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `filas_raw`  in  4  raw row lines; bit r high = key in row r conducting to the active column.
- `columnas`  out  4  one-hot active-high column drive.
- `key_code`  out  4  `{row_idx[1:0], col_idx[1:0]}` of the last accepted key; holds until the next key is accepted.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_held`  out  1  high while an accepted key is still down or in release debounce.

## Operation
- `filas_raw` passes through a 2-FF synchronizer, reset value 0; only the synchronized value `filas_s` is used.
- Column order is 4'b1000 → 0100 → 0010 → 0001 → 1000, with col_idx 0, 1, 2, 3 respectively. Row r corresponds to bit r.
- FSM states: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN:
  - The dwell counter counts 0..SCAN_CYCLES-1.
  - On the last dwell cycle, if `filas_s` is nonzero: latch col_idx and row_idx, where row_idx is the lowest set bit. Clear the debounce counter and go to DEBOUNCE.
  - Otherwise advance to the next column and reset dwell to 0.
- DEBOUNCE:
  - `columnas` is frozen.
  - If the latched row bit drops, go to SCAN on the same column with dwell 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bit still high:
    - Load `key_code`.
    - Pulse `key_valid` for that one cycle.
    - Go to HOLD.
- HOLD:
  - `columnas` is frozen and `key_held`=1.
  - When the latched row bit drops, clear the counter and go to RELEASE.
  - Other rows asserting are ignored.
- RELEASE:
  - `columnas` is frozen and `key_held`=1.
  - Requires DEBOUNCE_CYCLES consecutive cycles with the latched row bit low.
  - If the bit rises, go back to HOLD with no new pulse.
  - On completion, go to SCAN on the next column with dwell 0.
- Multi-key rule: only one key is tracked at a time, and a second key is never reported while the first is held.
- Counters are sized `$clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES))` and never wrap; they are cleared on every state entry.

## Timing
- Reset values: `columnas`=4'b1000, `key_code`=4'b0000, `key_valid`=0, `key_held`=0, state SCAN, dwell 0.
- Reset is asynchronous and may occur in any state, including mid-DEBOUNCE or HOLD. Outputs return to their reset values immediately, and no pulse is generated.
- Idle scan period is 4×SCAN_CYCLES cycles; `columnas` changes exactly on the edge after dwell = SCAN_CYCLES-1.
- Raw row change to `filas_s`: 2 cycles.
- Entering DEBOUNCE to `key_valid`: DEBOUNCE_CYCLES cycles.
- `key_code` and `key_valid` change on the same edge; `key_held` rises on the edge after.
- `key_valid` is never high on two consecutive cycles.

## Structure
- `keypad_pkg` holds:
  - state enum `scan_state_t`;
  - column constants `COL0..COL3` and `COL_RESET`=4'b1000;
  - `key_code` field widths.
- Sub-module `sync_2ff` (parameterized width): used for `filas_raw`.

## Test plan
All scenarios use SCAN_CYCLES=4 and DEBOUNCE_CYCLES=8.
- Reset released, no keys: `columnas` cycles 1000, 0100, 0010, 0001 with 4 cycles each; `key_valid` is never 1.
- Column 1000 active, `filas_raw`=0001 held 40 cycles: one `key_valid` pulse with `key_code`=4'b0000. `columnas` stays 1000 until 8 cycles after release, then becomes 0100.
- Bounce at column 1000, `filas_raw`=0001 for 3 cycles then 0: no `key_valid`, and scanning resumes.
- Column 0010 active, `filas_raw`=0010 held 40 cycles: `key_code`=4'b0110, one pulse.
- Column 0001 active, `filas_raw`=0101 held 40 cycles: `key_code`=4'b0011 (lowest row wins).
- Release glitch, `n_reset` mid-HOLD:
  - In RELEASE, a row glitch high for 2 cycles returns to HOLD with no second pulse.
  - Asserting `n_reset` during HOLD gives `columnas`=1000 and `key_held`=0 immediately.
